bju_ckpt: RTL and testbench
===========================

# bju_ckpt

Parametrised branch/jump resolution unit with an in-order GHSR checkpoint queue. It sits across IF and EX. IF allocates one checkpoint per predicted control-flow instruction. EX resolves the oldest checkpoint against the real outcome, producing a registered flush, redirect PC and exact GHSR restore value. It supports several in-flight branches, where the single-slot predecessor supported only one, and adds squash-on-flush, an ordering error flag and a mispredict counter.

## Interface
- XLEN, 32, datapath width
- GHSR_W, 8, global history width (>=2)
- DEPTH, 4, checkpoint entries (power of 2, >=2); TAG_W = $clog2(DEPTH)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- alloc_valid  in  1  IF allocates a checkpoint this cycle
- alloc_ghsr  in  GHSR_W  GHSR value the prediction used
- alloc_ready  out  1  queue not full
- alloc_tag  out  TAG_W  tag given to this allocation (tail pointer)
- ex_valid  in  1  control instruction present in EX
- ex_tag  in  TAG_W  tag carried from IF
- is_branch / is_jump / is_jumpr  in  1 each  one-hot instruction class
- funct3  in  3  branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111)
- left_operand, right_operand, pc, immediate_data  in  XLEN each
- pred_taken, pred_btb_hit  in  1 each  IF prediction
- pred_target  in  XLEN  BTB target
- flush  out  1  registered mispredict pulse
- redirect_pc  out  XLEN  correct next PC, valid with flush
- ghsr_restore  out  GHSR_W  corrected GHSR, valid with flush
- link_pc  out  XLEN  registered pc+4 of the last resolved instruction
- order_err  out  1  sticky: ex_tag != head, or resolve while empty
- mispredict_cnt  out  32  saturating mispredict counter

## Operation
- Queue storage: a circular GHSR array with head, tail and count registers. Allocation writes at tail; resolution pops at head.
- Allocation:
  - accepted when alloc_valid && (count<DEPTH || pop this cycle) && !mispredict this cycle.
  - alloc_ready = count<DEPTH, combinational.
- Resolution happens when ex_valid && (is_branch||is_jump||is_jumpr).
  - taken:
    - branch: per funct3. Signed compare for BLT/BGE, unsigned for BLTU/BGEU. Illegal funct3 gives not-taken.
    - jump / jumpr: always 1.
  - target:
    - jump: pc+imm.
    - jumpr: (rs1+imm) & ~1.
    - branch: taken ? pc+imm : pc+4.
  - mispredict = (taken != pred_taken) || (pred_btb_hit && pred_taken && taken && pred_target != target).
  - ghsr_restore = {head_ghsr[GHSR_W-2:0], taken}.
- Correct prediction: pop head; count-1.
- Mispredict: squash all entries (head=tail, count=0) and drop any same-cycle allocation. The resolved instruction's GHSR comes from ghsr_restore.
- order_err: if ex_tag != head or count==0, set order_err and treat the instruction as a mispredict. Use head_ghsr = alloc_ghsr if alloc_valid, else 0. order_err clears only on reset.
- mispredict_cnt: +1 per flush, saturates at 0xFFFF_FFFF.
- All arithmetic is modulo 2^XLEN. Pointers wrap modulo DEPTH.

## Timing
- Reset (async assert, sync deassert):
  - flush=0, redirect_pc=0, ghsr_restore=0, link_pc=0, order_err=0, mispredict_cnt=0.
  - head=tail=count=0, so alloc_ready=1 and alloc_tag=0.
  - Reset mid-operation discards all checkpoints immediately.
- Resolution latency is 1 cycle: EX in cycle N → flush, redirect_pc, ghsr_restore, link_pc registered at N+1. flush is high for exactly one cycle per mispredict.
- Queue state (head, tail, count) updates at the end of cycle N. Allocation in N+1 sees the squashed queue.
- Simultaneous alloc and correct pop when full: both take effect and count stays DEPTH.
- Non-control ex_valid: no pop, no outputs change except flush=0.

## Test plan
- Reset, then BEQ with operands 5/5, pc=0x100, imm=0x20, pred_taken=1, btb_hit=1, target 0x120 → no flush; count 1→0; link_pc=0x104.
- BLT with -1 vs 1 and BLTU with same operands, both pred_taken=0 → BLT flushes (redirect 0x100+imm); BLTU does not (0xFFFFFFFF > 1).
- GHSR_W=8, allocate 0x5A then 0x33. Resolve first with taken=1, pred 0 → flush; ghsr_restore=0xB5; count=0; second entry squashed; same-cycle alloc dropped.
- JALR rs1=0x1003, imm=0x4, pred_target 0x1000, btb_hit=1 → redirect_pc=0x1006, flush=1 (address mismatch).
- Fill DEPTH=4 entries → alloc_ready=0. Simultaneous alloc and correct resolve → accepted; tail wraps to 1 after a wrap sequence.
- Resolve with ex_tag=2 while head=0 → order_err=1 sticky, flush=1; assert reset mid-flush → all outputs 0 asynchronously.

Source files
------------

// File: rtl/bju_ckpt.sv
// bju_ckpt: branch/jump resolution unit with an in-order GHSR checkpoint queue.
//
// IF allocates one checkpoint (the GHSR its prediction used) per predicted
// control-flow instruction. EX resolves the oldest checkpoint against the real
// outcome. On a mispredict it raises a registered one-cycle flush with the
// correct redirect PC and restored GHSR, and squashes every younger checkpoint.
//
// Ports
//   clk, reset                  clock (rising edge), async active-high reset
//   alloc_valid, alloc_ghsr     IF checkpoint allocation request and its GHSR
//   alloc_ready, alloc_tag      queue not full / tag (tail) for this allocation
//   ex_valid, ex_tag            EX instruction present and its checkpoint tag
//   is_branch/is_jump/is_jumpr  one-hot instruction class
//   funct3                      branch condition
//   left_operand, right_operand branch compare operands (left is rs1 for jalr)
//   pc, immediate_data          instruction PC and immediate
//   pred_taken, pred_btb_hit    IF prediction
//   pred_target                 BTB predicted target
//   flush, redirect_pc          registered mispredict pulse and correct next PC
//   ghsr_restore                registered corrected GHSR
//   link_pc                     registered pc+4 of last resolved instruction
//   order_err                   sticky ordering error
//   mispredict_cnt              saturating mispredict counter
module bju_ckpt #(
  parameter int XLEN   = 32,
  parameter int GHSR_W = 8,
  parameter int DEPTH  = 4,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [GHSR_W-1:0] alloc_ghsr,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              ex_valid,
  input  logic [TAG_W-1:0]  ex_tag,
  input  logic              is_branch,
  input  logic              is_jump,
  input  logic              is_jumpr,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   left_operand,
  input  logic [XLEN-1:0]   right_operand,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   immediate_data,
  input  logic              pred_taken,
  input  logic              pred_btb_hit,
  input  logic [XLEN-1:0]   pred_target,
  output logic              flush,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [GHSR_W-1:0] ghsr_restore,
  output logic [XLEN-1:0]   link_pc,
  output logic              order_err,
  output logic [31:0]       mispredict_cnt
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(DEPTH);

  function automatic logic br_taken(input logic [2:0] f3,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [GHSR_W-1:0] ghsr_q [DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count;

  logic              resolve_p0;
  logic              order_bad_p0;
  logic              taken_p0;
  logic [XLEN-1:0]   target_p0;
  logic [XLEN-1:0]   jr_sum_p0;
  logic [GHSR_W-1:0] head_ghsr_p0;
  logic              mispredict_p0;
  logic              pop_p0;
  logic              alloc_ok_p0;

  assign alloc_ready = (count != DEPTH_C);
  assign alloc_tag   = tail;

  // Stage p0: combinational resolution in EX
  always_comb begin
    resolve_p0   = ex_valid && (is_branch || is_jump || is_jumpr);
    order_bad_p0 = resolve_p0 && ((ex_tag != head) || (count == '0));
    jr_sum_p0    = left_operand + immediate_data;

    taken_p0  = 1'b0;
    target_p0 = pc + XLEN'(4);
    if (is_jump) begin
      taken_p0  = 1'b1;
      target_p0 = pc + immediate_data;
    end else if (is_jumpr) begin
      taken_p0  = 1'b1;
      target_p0 = {jr_sum_p0[XLEN-1:1], 1'b0};
    end else if (is_branch) begin
      taken_p0  = br_taken(funct3, left_operand, right_operand);
      target_p0 = taken_p0 ? (pc + immediate_data) : (pc + XLEN'(4));
    end

    // An out-of-order resolve has no trustworthy head entry; fall back to the
    // GHSR IF is presenting this cycle, or zero.
    if (order_bad_p0)
      head_ghsr_p0 = alloc_valid ? alloc_ghsr : '0;
    else
      head_ghsr_p0 = ghsr_q[head];

    mispredict_p0 = resolve_p0 &&
                    (order_bad_p0 || (taken_p0 != pred_taken) ||
                     (pred_btb_hit && pred_taken && taken_p0 &&
                      (pred_target != target_p0)));
    pop_p0        = resolve_p0 && !mispredict_p0;
    // A pop frees a slot in the same cycle, so a full queue still accepts.
    alloc_ok_p0   = alloc_valid && (alloc_ready || pop_p0) && !mispredict_p0;
  end

  // Stage p1: checkpoint storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (alloc_ok_p0)
      ghsr_q[tail] <= alloc_ghsr;
  end

  // Stage p1: queue pointers and registered resolution outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
      ghsr_restore   <= '0;
      link_pc        <= '0;
      order_err      <= 1'b0;
      mispredict_cnt <= '0;
    end else begin
      flush <= mispredict_p0;
      if (resolve_p0)
        link_pc <= pc + XLEN'(4);
      if (order_bad_p0)
        order_err <= 1'b1;

      if (mispredict_p0) begin
        redirect_pc    <= target_p0;
        ghsr_restore   <= {head_ghsr_p0[GHSR_W-2:0], taken_p0};
        mispredict_cnt <= sat_inc(mispredict_cnt);
        // Squash every in-flight checkpoint; the same-cycle alloc is dropped.
        head  <= tail;
        count <= '0;
      end else begin
        if (pop_p0)
          head <= head + TAG_W'(1);
        if (alloc_ok_p0)
          tail <= tail + TAG_W'(1);
        case ({alloc_ok_p0, pop_p0})
          2'b10:   count <= count + (TAG_W+1)'(1);
          2'b01:   count <= count - (TAG_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bju_ckpt.sv
// Directed bench for bju_ckpt (XLEN=32, GHSR_W=8, DEPTH=4).
module tb_bju_ckpt;

  localparam int XLEN   = 32;
  localparam int GHSR_W = 8;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic [GHSR_W-1:0] alloc_ghsr;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              ex_valid;
  logic [TAG_W-1:0]  ex_tag;
  logic              is_branch, is_jump, is_jumpr;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   left_operand, right_operand, pc, immediate_data;
  logic              pred_taken, pred_btb_hit;
  logic [XLEN-1:0]   pred_target;
  logic              flush;
  logic [XLEN-1:0]   redirect_pc;
  logic [GHSR_W-1:0] ghsr_restore;
  logic [XLEN-1:0]   link_pc;
  logic              order_err;
  logic [31:0]       mispredict_cnt;

  int checks = 0;
  int errors = 0;

  bju_ckpt #(.XLEN(XLEN), .GHSR_W(GHSR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ghsr(alloc_ghsr),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .ex_valid(ex_valid), .ex_tag(ex_tag),
    .is_branch(is_branch), .is_jump(is_jump), .is_jumpr(is_jumpr),
    .funct3(funct3),
    .left_operand(left_operand), .right_operand(right_operand),
    .pc(pc), .immediate_data(immediate_data),
    .pred_taken(pred_taken), .pred_btb_hit(pred_btb_hit),
    .pred_target(pred_target),
    .flush(flush), .redirect_pc(redirect_pc), .ghsr_restore(ghsr_restore),
    .link_pc(link_pc), .order_err(order_err), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_ghsr = '0;
    ex_valid = 0; ex_tag = '0;
    is_branch = 0; is_jump = 0; is_jumpr = 0; funct3 = '0;
    left_operand = '0; right_operand = '0; pc = '0; immediate_data = '0;
    pred_taken = 0; pred_btb_hit = 0; pred_target = '0;
  endtask

  task automatic alloc(input logic [GHSR_W-1:0] g);
    idle();
    alloc_valid = 1; alloc_ghsr = g;
    step();
    idle();
  endtask

  task automatic branch(input logic [TAG_W-1:0] tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] imm,
                        input logic pt, input logic hit, input logic [31:0] tgt);
    ex_valid = 1; ex_tag = tag; is_branch = 1; funct3 = f3;
    left_operand = a; right_operand = b; pc = p; immediate_data = imm;
    pred_taken = pt; pred_btb_hit = hit; pred_target = tgt;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_redirect", 64'(redirect_pc), 64'd0);
    chk("rst_ghsr", 64'(ghsr_restore), 64'd0);
    chk("rst_link", 64'(link_pc), 64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    chk("rst_cnt", 64'(mispredict_cnt), 64'd0);
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_tag", 64'(alloc_tag), 64'd0);
    reset = 0;

    // BEQ 5==5, correctly predicted taken with matching target
    alloc(8'h11);
    chk("t1_tag", 64'(alloc_tag), 64'd1);
    branch(2'd0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b1, 32'h120);
    step(); idle();
    chk("t1_flush", 64'(flush), 64'd0);
    chk("t1_link", 64'(link_pc), 64'h104);
    chk("t1_cnt", 64'(mispredict_cnt), 64'd0);

    // Non-control EX: no pop, link_pc unchanged
    ex_valid = 1; ex_tag = 2'd1; pc = 32'h900;
    step(); idle();
    chk("nc_flush", 64'(flush), 64'd0);
    chk("nc_link", 64'(link_pc), 64'h104);

    // BLT -1 < 1 (signed) taken, predicted not-taken
    alloc(8'h00);
    branch(2'd1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 1'b0, 1'b0, 32'h0);
    step(); idle();
    chk("blt_flush", 64'(flush), 64'd1);
    chk("blt_redirect", 64'(redirect_pc), 64'h140);
    chk("blt_ghsr", 64'(ghsr_restore), 64'h01);
    chk("blt_cnt", 64'(mispredict_cnt), 64'd1);
    step();
    chk("blt_flush_pulse", 64'(flush), 64'd0);

    // BLTU 0xFFFFFFFF < 1 is false: not taken, predicted not-taken
    alloc(8'h00);
    branch(2'd2, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0, 1'b0, 32'h0);
    step(); idle();
    chk("bltu_flush", 64'(flush), 64'd0);
    chk("bltu_link", 64'(link_pc), 64'h204);
    chk("bltu_cnt", 64'(mispredict_cnt), 64'd1);

    // Two checkpoints 0x5A (tag 3), 0x33 (tag 0); first mispredicts taken,
    // same-cycle allocation is dropped
    alloc(8'h5A);
    alloc(8'h33);
    chk("t3_tag", 64'(alloc_tag), 64'd1);
    branch(2'd3, 3'b000, 32'd1, 32'd1, 32'h300, 32'h8, 1'b0, 1'b0, 32'h0);
    alloc_valid = 1; alloc_ghsr = 8'h77;
    step(); idle();
    chk("t3_flush", 64'(flush), 64'd1);
    chk("t3_ghsr", 64'(ghsr_restore), 64'hB5);
    chk("t3_redirect", 64'(redirect_pc), 64'h308);
    chk("t3_tag_after", 64'(alloc_tag), 64'd1);
    chk("t3_cnt", 64'(mispredict_cnt), 64'd2);

    // JALR (0x1003+4)&~1 = 0x1006 vs BTB 0x1000
    alloc(8'h0F);
    ex_valid = 1; ex_tag = 2'd1; is_jumpr = 1;
    left_operand = 32'h1003; immediate_data = 32'h4; pc = 32'h500;
    pred_taken = 1; pred_btb_hit = 1; pred_target = 32'h1000;
    step(); idle();
    chk("jalr_flush", 64'(flush), 64'd1);
    chk("jalr_redirect", 64'(redirect_pc), 64'h1006);
    chk("jalr_ghsr", 64'(ghsr_restore), 64'h1F);
    chk("jalr_link", 64'(link_pc), 64'h504);
    chk("jalr_cnt", 64'(mispredict_cnt), 64'd3);

    // Fill four entries (tags 2,3,0,1): queue empty after squashes
    alloc(8'hA0);
    alloc(8'hA1);
    alloc(8'hA2);
    chk("fill_ready3", 64'(alloc_ready), 64'd1);
    alloc(8'hA3);
    chk("fill_ready4", 64'(alloc_ready), 64'd0);
    chk("fill_tag", 64'(alloc_tag), 64'd2);

    // Full: alloc + correct JAL pop in the same cycle, both accepted
    ex_valid = 1; ex_tag = 2'd2; is_jump = 1; pc = 32'h600; immediate_data = 32'h10;
    pred_taken = 1; pred_btb_hit = 1; pred_target = 32'h610;
    alloc_valid = 1; alloc_ghsr = 8'h44;
    step(); idle();
    chk("full_flush", 64'(flush), 64'd0);
    chk("full_link", 64'(link_pc), 64'h604);
    chk("full_tag", 64'(alloc_tag), 64'd3);
    chk("full_ready", 64'(alloc_ready), 64'd0);

    // BGE 1 >= -1 (signed) taken, correctly predicted
    branch(2'd3, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'h700, 32'h10, 1'b1, 1'b0, 32'h0);
    step(); idle();
    chk("bge_flush", 64'(flush), 64'd0);
    chk("bge_ready", 64'(alloc_ready), 64'd1);
    chk("bge_cnt", 64'(mispredict_cnt), 64'd3);

    // Out-of-order tag: head is 0, resolve tag 2 (correct otherwise)
    branch(2'd2, 3'b000, 32'd0, 32'd0, 32'h800, 32'h20, 1'b1, 1'b0, 32'h0);
    step(); idle();
    chk("oe_flush", 64'(flush), 64'd1);
    chk("oe_err", 64'(order_err), 64'd1);
    chk("oe_ghsr", 64'(ghsr_restore), 64'h01);
    chk("oe_redirect", 64'(redirect_pc), 64'h820);
    chk("oe_cnt", 64'(mispredict_cnt), 64'd4);
    step();
    chk("oe_sticky", 64'(order_err), 64'd1);
    chk("oe_pulse", 64'(flush), 64'd0);

    // Resolve while empty, then async reset while flush is high
    branch(2'd3, 3'b001, 32'd1, 32'd2, 32'h900, 32'h40, 1'b1, 1'b0, 32'h0);
    step(); idle();
    chk("emp_flush", 64'(flush), 64'd1);
    chk("emp_redirect", 64'(redirect_pc), 64'h940);
    #2 reset = 1;
    #1;
    chk("ar_flush", 64'(flush), 64'd0);
    chk("ar_redirect", 64'(redirect_pc), 64'd0);
    chk("ar_ghsr", 64'(ghsr_restore), 64'd0);
    chk("ar_link", 64'(link_pc), 64'd0);
    chk("ar_err", 64'(order_err), 64'd0);
    chk("ar_cnt", 64'(mispredict_cnt), 64'd0);
    chk("ar_ready", 64'(alloc_ready), 64'd1);
    chk("ar_tag", 64'(alloc_tag), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
